// File: rtl/serial_tx_fifo_pkg.sv
// Shared I2S types for the serial transmit FIFO: frame sizes, serializer states
// and the frame-size-to-bit-count helper.
package serial_tx_fifo_pkg;

  typedef enum logic [1:0] {
    f16bits = 2'd0,
    f24bits = 2'd1,
    f32bits = 2'd2
  } frame_size_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_t;

  // Unused encoding falls back to the widest frame
  function automatic int frame_bits(frame_size_t fs);
    case (fs)
      f16bits: return 16;
      f24bits: return 24;
      default: return 32;
    endcase
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial shifter for one FIFO word per frame, MSB first, with
// back-to-back word loads and zero-word substitution on underrun.
//
// state   | meaning
// S_IDLE  | not transmitting; dout held low, waiting for rd_en && bit_tick
// S_SHIFT | word in sreg; dout shows sreg[maxp_q], bcnt bits remain after it
module word_serializer
  import serial_tx_fifo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             pclk,
  input  logic             rst_,
  input  logic             rd_en,
  input  logic             bit_tick,
  input  logic             mute,
  input  logic             empty,
  input  frame_size_t      frame_size,
  input  logic [WIDTH-1:0] head,
  output logic             load_pop,
  output logic             load_urun,
  output logic             dout,
  output logic             word_start
);

  localparam int BCW = $clog2(WIDTH);

  ser_state_t       state;
  logic [BCW-1:0]   bcnt;
  logic [BCW-1:0]   maxp_q;
  logic [BCW-1:0]   maxp_new;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_sh;
  logic             load;
  int               nbits;

  always_comb begin
    nbits = frame_bits(frame_size);
    if (nbits > WIDTH) nbits = WIDTH;
    maxp_new = BCW'(nbits - 1);
  end

  // A load happens on the first tick from idle or on the tick after the last bit
  assign load      = rd_en && bit_tick && (state == S_IDLE || bcnt == '0);
  assign load_pop  = load && !empty;
  assign load_urun = load && empty;
  assign sreg_sh   = {sreg[WIDTH-2:0], 1'b0};

  always_ff @(posedge pclk or negedge rst_) begin
    if (!rst_) begin
      state      <= S_IDLE;
      bcnt       <= '0;
      maxp_q     <= '0;
      sreg       <= '0;
      dout       <= 1'b0;
      word_start <= 1'b0;
    end else begin
      word_start <= 1'b0;
      if (!rd_en) begin
        state <= S_IDLE;
        bcnt  <= '0;
        sreg  <= '0;
        dout  <= 1'b0;
      end else if (load) begin
        state      <= S_SHIFT;
        sreg       <= empty ? '0 : head;
        maxp_q     <= maxp_new;
        bcnt       <= maxp_new;
        word_start <= 1'b1;
        dout       <= !mute && !empty && head[maxp_new];
      end else if (state == S_SHIFT && bit_tick) begin
        sreg <= sreg_sh;
        bcnt <= bcnt - 1'b1;
        dout <= !mute && sreg_sh[maxp_q];
      end else if (state == S_SHIFT) begin
        dout <= !mute && sreg[maxp_q];
      end else begin
        dout <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_tx_fifo.sv
// Transmit FIFO feeding a serial word serializer, with occupancy and sticky error flags.
// Define SERIAL_TX_FIFO_LEVEL_EN to expose the current fill level on port level.
module serial_tx_fifo
  import serial_tx_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ADDR  = 3
) (
  input  logic             pclk,
  input  logic             rst_,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  input  logic             bit_tick,
  input  frame_size_t      frame_size,
  input  logic             mute,
  input  logic [ADDR:0]    ae_thr,
  input  logic [ADDR:0]    af_thr,
  input  logic             clr_err,
  output logic             dout,
  output logic             word_start,
  output logic             full,
  output logic             empty,
  output logic             al_full,
  output logic             al_empty,
  output logic             underrun,
`ifdef SERIAL_TX_FIFO_LEVEL_EN
  output logic             overflow,
  output logic [ADDR:0]    level
`else
  output logic             overflow
`endif
);

  localparam int DEPTH = 2 ** ADDR;
  localparam logic [ADDR:0] DEPTH_V = {1'b1, {ADDR{1'b0}}};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR:0]    wptr;
  logic [ADDR:0]    rptr;
  logic [ADDR:0]    lvl;
  logic             wr_acc;
  logic             pop;
  logic             urun;

  assign lvl      = wptr - rptr;
  assign full     = (lvl == DEPTH_V);
  assign empty    = (lvl == '0);
  assign al_full  = (lvl >= af_thr);
  assign al_empty = (lvl <= ae_thr);

  // Full is judged on the registered level, so a same-cycle pop never frees a slot
  assign wr_acc = wr_en && !full;

`ifdef SERIAL_TX_FIFO_LEVEL_EN
  assign level = lvl;
`else
`endif

  always_ff @(posedge pclk) begin
    if (wr_acc) mem[wptr[ADDR-1:0]] <= din;
  end

  always_ff @(posedge pclk or negedge rst_) begin
    if (!rst_) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (pop)    rptr <= rptr + 1'b1;
    end
  end

  // A fresh error event outranks a coincident clear
  always_ff @(posedge pclk or negedge rst_) begin
    if (!rst_) begin
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (urun)         underrun <= 1'b1;
      else if (clr_err) underrun <= 1'b0;
      if (wr_en && full) overflow <= 1'b1;
      else if (clr_err)  overflow <= 1'b0;
    end
  end

  word_serializer #(.WIDTH(WIDTH)) u_ser (
    .pclk       (pclk),
    .rst_       (rst_),
    .rd_en      (rd_en),
    .bit_tick   (bit_tick),
    .mute       (mute),
    .empty      (empty),
    .frame_size (frame_size),
    .head       (mem[rptr[ADDR-1:0]]),
    .load_pop   (pop),
    .load_urun  (urun),
    .dout       (dout),
    .word_start (word_start)
  );

endmodule
